// File: rtl/writeback_arbiter_pkg.sv
// rtl/writeback_arbiter_pkg.sv - shared types and constants for the writeback arbiter
//
// Package wb_pkg:
//   XLEN, REG_AW : datapath and register-address widths
//   XZR          : architectural zero register (writes are discarded)
//   wb_entry_t   : one register-file write {rd, data}
//   wb_src_t     : which source won the write port this cycle
//   rd_onehot()  : decode a register index into a 32-bit mask
package wb_pkg;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] XZR = 5'd31;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_ALU    = 2'd1,
        SRC_FIFO   = 2'd2,
        SRC_BYPASS = 2'd3
    } wb_src_t;

    function automatic logic [31:0] rd_onehot(input logic [REG_AW-1:0] rd);
        return 32'd1 << rd;
    endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// rtl/writeback_arbiter_if.sv - result-source handshake bundle into the writeback arbiter
//
// Signals:
//   alu_valid/alu_ready/alu_rd/alu_data : single-cycle ALU result stream
//   mem_valid/mem_ready/mem_rd/mem_data : variable-latency load return stream
// Modports:
//   master : execute/memory stages driving results
//   slave  : the writeback arbiter consuming them
interface writeback_arbiter_if;
    import wb_pkg::*;

    logic              alu_valid;
    logic              alu_ready;
    logic [REG_AW-1:0] alu_rd;
    logic [XLEN-1:0]   alu_data;

    logic              mem_valid;
    logic              mem_ready;
    logic [REG_AW-1:0] mem_rd;
    logic [XLEN-1:0]   mem_data;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        input  alu_ready, mem_ready
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        output alu_ready, mem_ready
    );

endinterface

// File: rtl/writeback_arbiter_fifo.sv
// rtl/writeback_arbiter_fifo.sv - load-return buffer for the writeback arbiter
//
// Module wb_fifo, parameter DEPTH (power of two, >= 2)
//   clk, rst_n   : clock, asynchronous active-low reset (empties the FIFO)
//   push, push_entry : write one entry; honoured when not full, or when full with pop
//   pop          : retire the head entry; ignored when empty
//   full, empty  : occupancy flags
//   head         : oldest entry, valid while not empty
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t     mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // DEPTH is a power of two, so the occupancy counter's MSB alone marks full.
    assign full  = count[AW];
    assign empty = (count == '0);
    assign head  = mem[rptr];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage needs no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - serialises ALU and load results onto the register-file write port
//
// Parameter DEPTH : load-return FIFO entries (power of two, >= 2)
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   wb (slave)            : ALU and load-return handshake streams
//   mem_issue/_rd         : load issued this cycle; marks its destination pending
//   chk_rn/chk_rm/chk_rd  : decode's registers to test against pending loads
//   hazard                : any checked register has a load outstanding
//   sb_err                : sticky; a load was issued to an already-pending register
//   Rd/dataWrite/regWR    : registered register-file write port
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    writeback_arbiter_if.slave  wb,
    input  logic                mem_issue,
    input  logic [REG_AW-1:0]   mem_issue_rd,
    input  logic [REG_AW-1:0]   chk_rn,
    input  logic [REG_AW-1:0]   chk_rm,
    input  logic [REG_AW-1:0]   chk_rd,
    output logic                hazard,
    output logic                sb_err,
    output logic [REG_AW-1:0]   Rd,
    output logic [XLEN-1:0]     dataWrite,
    output logic                regWR
);

    logic      fifo_full;
    logic      fifo_empty;
    logic      fifo_push;
    logic      fifo_pop;
    wb_entry_t fifo_head;
    wb_entry_t mem_entry;

    wb_src_t   win_src;
    wb_entry_t win;
    logic      win_is_load;
    logic      win_writes;

    logic        wr_is_load;
    logic [31:0] pending;
    logic [31:0] pending_vis;
    logic [31:0] set_vec;
    logic [31:0] clr_vec;

    assign mem_entry = '{rd: wb.mem_rd, data: wb.mem_data};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fifo_push),
        .push_entry (mem_entry),
        .pop        (fifo_pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (fifo_head)
    );

    // The FIFO counter resets asynchronously, so both readies rise as soon
    // as rst_n falls.
    assign wb.alu_ready = !fifo_full;
    assign wb.mem_ready = !fifo_full;

    // One winner per cycle. A full FIFO must drain first, otherwise the ALU
    // has priority and any accepted load return queues behind it. Bypass is
    // only legal when nothing older is buffered, which keeps loads in order.
    always_comb begin
        win_src   = SRC_NONE;
        win       = '0;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        if (fifo_full) begin
            win_src  = SRC_FIFO;
            win      = fifo_head;
            fifo_pop = 1'b1;
        end else if (wb.alu_valid) begin
            win_src   = SRC_ALU;
            win       = '{rd: wb.alu_rd, data: wb.alu_data};
            fifo_push = wb.mem_valid;
        end else if (!fifo_empty) begin
            win_src   = SRC_FIFO;
            win       = fifo_head;
            fifo_pop  = 1'b1;
            fifo_push = wb.mem_valid;
        end else if (wb.mem_valid) begin
            win_src = SRC_BYPASS;
            win     = mem_entry;
        end
    end

    assign win_is_load = (win_src == SRC_FIFO) || (win_src == SRC_BYPASS);
    // Writes to XZR are consumed from their source but never reach the port.
    assign win_writes  = (win_src != SRC_NONE) && (win.rd != XZR);

    // Rd/dataWrite hold across idle and XZR cycles; only regWR pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regWR      <= 1'b0;
            Rd         <= '0;
            dataWrite  <= '0;
            wr_is_load <= 1'b0;
        end else if (win_writes) begin
            regWR      <= 1'b1;
            Rd         <= win.rd;
            dataWrite  <= win.data;
            wr_is_load <= win_is_load;
        end else begin
            regWR      <= 1'b0;
            wr_is_load <= 1'b0;
        end
    end

    // A pending bit clears on the edge its load-sourced write is presented to
    // the register file, so decode sees the fresh value from the read port in
    // the cycle the hazard drops. ALU writes to the same register do not clear it.
    assign clr_vec = (regWR && wr_is_load) ? rd_onehot(Rd) : 32'd0;
    assign set_vec = (mem_issue && (mem_issue_rd != XZR)) ? rd_onehot(mem_issue_rd) : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            sb_err  <= 1'b0;
        end else begin
            pending <= (pending & ~clr_vec) | set_vec;
            if (|(set_vec & pending & ~clr_vec)) begin
                sb_err <= 1'b1;
            end
        end
    end

    // XZR never carries a dependency.
    assign pending_vis = {1'b0, pending[30:0]};
    assign hazard      = pending_vis[chk_rn] | pending_vis[chk_rm] | pending_vis[chk_rd];

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - directed self-checking bench for writeback_arbiter
module tb_writeback_arbiter;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_issue;
    logic [4:0]  mem_issue_rd;
    logic [4:0]  chk_rn;
    logic [4:0]  chk_rm;
    logic [4:0]  chk_rd;
    logic        hazard;
    logic        sb_err;
    logic [4:0]  Rd;
    logic [63:0] dataWrite;
    logic        regWR;

    int errors = 0;
    int checks = 0;

    writeback_arbiter_if bus ();

    writeback_arbiter #(
        .DEPTH (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb           (bus),
        .mem_issue    (mem_issue),
        .mem_issue_rd (mem_issue_rd),
        .chk_rn       (chk_rn),
        .chk_rm       (chk_rm),
        .chk_rd       (chk_rd),
        .hazard       (hazard),
        .sb_err       (sb_err),
        .Rd           (Rd),
        .dataWrite    (dataWrite),
        .regWR        (regWR)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.alu_valid = 1'b0;
        bus.alu_rd    = 5'd0;
        bus.alu_data  = 64'd0;
        bus.mem_valid = 1'b0;
        bus.mem_rd    = 5'd0;
        bus.mem_data  = 64'd0;
        mem_issue     = 1'b0;
        mem_issue_rd  = 5'd0;
        chk_rn        = 5'd31;
        chk_rm        = 5'd31;
        chk_rd        = 5'd31;
    endtask

    task automatic issue(input logic [4:0] rd);
        mem_issue    = 1'b1;
        mem_issue_rd = rd;
        tick();
        mem_issue    = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle_inputs();
        #3;
        checks++; if (regWR !== 1'b0) begin errors++; $display("FAIL reset_regwr got=%0h exp=0", regWR); end
        checks++; if (Rd !== 5'd0) begin errors++; $display("FAIL reset_rd got=%0h exp=0", Rd); end
        checks++; if (dataWrite !== 64'd0) begin errors++; $display("FAIL reset_data got=%0h exp=0", dataWrite); end
        checks++; if (hazard !== 1'b0 || sb_err !== 1'b0) begin errors++; $display("FAIL reset_sb got=%b%b exp=00", hazard, sb_err); end
        checks++; if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b%b exp=11", bus.alu_ready, bus.mem_ready); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu_write;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_data  = 64'h1234;
        tick();
        bus.alu_valid = 1'b0;
        checks++; if (regWR !== 1'b1) begin errors++; $display("FAIL alu_regwr got=%0h exp=1", regWR); end
        checks++; if (Rd !== 5'd5) begin errors++; $display("FAIL alu_rd got=%0d exp=5", Rd); end
        checks++; if (dataWrite !== 64'h1234) begin errors++; $display("FAIL alu_data got=%0h exp=1234", dataWrite); end
        tick();
        checks++; if (regWR !== 1'b0) begin errors++; $display("FAIL alu_regwr_pulse got=%0h exp=0", regWR); end
    endtask

    task automatic test_load_round_trip;
        issue(5'd9);
        chk_rn = 5'd9;
        #1;
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL load_hazard_set got=%0h exp=1", hazard); end
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd9;
        bus.mem_data  = 64'h1000;
        tick();
        bus.mem_valid = 1'b0;
        checks++; if (regWR !== 1'b1 || Rd !== 5'd9 || dataWrite !== 64'h1000) begin errors++; $display("FAIL load_write got=%0h/%0d/%0h exp=1/9/1000", regWR, Rd, dataWrite); end
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL load_hazard_hold got=%0h exp=1", hazard); end
        tick();
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL load_hazard_clear got=%0h exp=0", hazard); end
        chk_rn = 5'd31;
    endtask

    task automatic test_contention;
        logic [4:0] exp_rd  [7];
        logic       exp_rdy [7];
        logic [4:0] r;
        int ai, mi, wn;
        logic a_acc, m_acc;
        exp_rd  = '{5'd10, 5'd11, 5'd1, 5'd12, 5'd2, 5'd13, 5'd3};
        exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        issue(5'd1);
        issue(5'd2);
        issue(5'd3);
        ai = 0; mi = 0; wn = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            bus.alu_valid = (ai < 4);
            bus.alu_rd    = 5'(10 + ai);
            bus.alu_data  = 64'hA00 + 64'(10 + ai);
            bus.mem_valid = (mi < 3);
            bus.mem_rd    = 5'(1 + mi);
            bus.mem_data  = 64'h100 + 64'(1 + mi);
            #1;
            if (cyc < 7) begin
                checks++;
                if (bus.alu_ready !== exp_rdy[cyc] || bus.mem_ready !== exp_rdy[cyc]) begin
                    errors++; $display("FAIL cont_ready cyc=%0d got=%b%b exp=%b%b", cyc, bus.alu_ready, bus.mem_ready, exp_rdy[cyc], exp_rdy[cyc]);
                end
            end
            a_acc = bus.alu_valid && bus.alu_ready;
            m_acc = bus.mem_valid && bus.mem_ready;
            tick();
            if (a_acc) ai++;
            if (m_acc) mi++;
            if (regWR === 1'b1) begin
                checks++;
                if (wn >= 7) begin
                    errors++; $display("FAIL cont_extra_write got=%0d exp=none", Rd);
                end else begin
                    r = exp_rd[wn];
                    if (Rd !== r || dataWrite !== ((r < 5'd10) ? 64'h100 + 64'(r) : 64'hA00 + 64'(r))) begin
                        errors++; $display("FAIL cont_write n=%0d got=%0d/%0h exp=%0d", wn, Rd, dataWrite, r);
                    end
                end
                wn++;
            end
        end
        idle_inputs();
        checks++; if (wn != 7) begin errors++; $display("FAIL cont_write_count got=%0d exp=7", wn); end
        chk_rn = 5'd1; chk_rm = 5'd2; chk_rd = 5'd3;
        #1;
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL cont_hazard_clear got=%0h exp=0", hazard); end
        chk_rn = 5'd31; chk_rm = 5'd31; chk_rd = 5'd31;
    endtask

    task automatic test_xzr;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd31; bus.alu_data = 64'hDEAD;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd31; bus.mem_data = 64'hBEEF;
        mem_issue = 1'b1; mem_issue_rd = 5'd31;
        tick();
        bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
        checks++; if (regWR !== 1'b0) begin errors++; $display("FAIL xzr_alu_regwr got=%0h exp=0", regWR); end
        checks++; if (Rd !== 5'd3 || dataWrite !== 64'h103) begin errors++; $display("FAIL xzr_hold got=%0d/%0h exp=3/103", Rd, dataWrite); end
        tick();
        mem_issue = 1'b0;
        checks++; if (regWR !== 1'b0) begin errors++; $display("FAIL xzr_load_regwr got=%0h exp=0", regWR); end
        checks++; if (sb_err !== 1'b0 || hazard !== 1'b0) begin errors++; $display("FAIL xzr_issue got=%b%b exp=00", sb_err, hazard); end
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 64'h77;
        tick();
        bus.mem_valid = 1'b0;
        checks++; if (regWR !== 1'b1 || Rd !== 5'd7 || dataWrite !== 64'h77) begin errors++; $display("FAIL xzr_drain got=%0h/%0d/%0h exp=1/7/77", regWR, Rd, dataWrite); end
        tick();
    endtask

    task automatic test_scoreboard_edges;
        issue(5'd4);
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd4; bus.mem_data = 64'h44;
        tick();
        bus.mem_valid = 1'b0;
        checks++; if (regWR !== 1'b1 || Rd !== 5'd4) begin errors++; $display("FAIL sb_load_write got=%0h/%0d exp=1/4", regWR, Rd); end
        issue(5'd4);
        chk_rn = 5'd4;
        #1;
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL sb_set_wins got=%0h exp=1", hazard); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL sb_no_err got=%0h exp=0", sb_err); end
        tick();
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL sb_still_pending got=%0h exp=1", hazard); end
        issue(5'd4);
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL sb_err_set got=%0h exp=1", sb_err); end
        tick();
        tick();
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL sb_err_sticky got=%0h exp=1", sb_err); end
        chk_rn = 5'd31;
    endtask

    task automatic test_reset_mid;
        issue(5'd5);
        issue(5'd6);
        issue(5'd8);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd12; bus.alu_data = 64'hC12;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd5;  bus.mem_data = 64'h105;
        tick();
        bus.alu_rd = 5'd13; bus.alu_data = 64'hC13;
        bus.mem_rd = 5'd6;  bus.mem_data = 64'h106;
        tick();
        idle_inputs();
        chk_rn = 5'd5; chk_rm = 5'd6; chk_rd = 5'd8;
        #1;
        checks++; if (bus.mem_ready !== 1'b0 || regWR !== 1'b1 || hazard !== 1'b1) begin errors++; $display("FAIL rst_pre got=%b%b%b exp=011", bus.mem_ready, regWR, hazard); end
        rst_n = 1'b0;
        #1;
        checks++; if (regWR !== 1'b0) begin errors++; $display("FAIL rst_regwr got=%0h exp=0", regWR); end
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL rst_hazard got=%0h exp=0", hazard); end
        checks++; if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b%b exp=11", bus.alu_ready, bus.mem_ready); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL rst_sb_err got=%0h exp=0", sb_err); end
        tick();
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (regWR !== 1'b0) begin errors++; $display("FAIL rst_no_write i=%0d got=%0h exp=0", i, regWR); end
        end
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_load_round_trip();
        test_contention();
        test_xzr();
        test_scoreboard_edges();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
